fpu_result_buf: RTL

FPU_RESULT_BUF -- requirements
Module: fpu_result_buf

---
 rtl/fpu_result_buf.sv | 104 ++++++++++
 1 files changed

// File: rtl/fpu_result_buf.sv
// Result buffer for a fixed-latency FPU datapath.
// Launches are granted only when the buffer has room for every result that is
// already in flight plus the new one, so results never need to be back-pressured.
module fpu_result_buf #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_req,
   output logic                         issue_gnt,
   input  logic                         res_valid,
   input  logic [WIDTH-1:0]             res_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned SW = CW + 1;

   logic [CW-1:0]    infl_q;
   logic [CW-1:0]    infl_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [CW-1:0]    level_d;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    rd_ptr_d;
   logic             err_q;
   logic             err_d;
   logic [SW-1:0]    occ;
   logic             res_bad;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] mem [DEPTH];

   // Grant/push/pop decode and next-state computation for counters and pointers
   always_comb begin
      occ       = SW'(infl_q) + SW'(cnt_q);
      issue_gnt = issue_req && (occ < SW'(DEPTH)) && !rst;
      out_valid = (cnt_q != '0);
      out_data  = mem[rd_ptr_q];
      res_bad   = res_valid && ((infl_q == '0) || (cnt_q == CW'(DEPTH)));
      push      = res_valid && !res_bad;
      pop       = out_valid && out_ready;

      infl_d   = infl_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q || res_bad;

      // In-flight count: a discarded result does not retire an operation
      case ({issue_gnt, push})
         2'b10:   infl_d = infl_q + CW'(1);
         2'b01:   infl_d = infl_q - CW'(1);
         default: infl_d = infl_q;
      endcase

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      level_d = infl_d + cnt_d;
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         infl_q   <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
         level    <= '0;
      end else begin
         infl_q   <= infl_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
         level    <= level_d;
      end
   end

   // Result storage; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr_q] <= res_data;
   end

   assign err = err_q;

endmodule
